rr_priority_picker: RTL



---
 rtl/rr_priority_picker_pkg.sv | 7 +
 rtl/rr_find_first.sv | 22 ++
 rtl/rr_priority_picker.sv | 70 +++++++
 3 files changed

// File: rtl/rr_priority_picker_pkg.sv
// rr_priority_picker_pkg: mode encodings and default sizing shared by issue and fetch arbiters
package rr_priority_picker_pkg;
    localparam logic PICK_FIXED  = 1'b0;
    localparam logic PICK_RR     = 1'b1;
    localparam int   DEF_NUM_REQ = 40;
    localparam int   DEF_IDX_W   = 6;
endpackage

// File: rtl/rr_find_first.sv
// rr_find_first: combinational find-first-set at or above ptr, wrapping via a doubled vector
module rr_find_first #(
    parameter int N = 40,
    parameter int W = 6
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         found
);
    logic [N-1:0] sh;
    int off;
    int s;
    always_comb begin
        sh = N'({vec, vec} >> ptr);
        off = 0;
        for (int i = N - 1; i >= 0; i--) if (sh[i]) off = i;
        s = int'(ptr) + off;
        idx = W'(s >= N ? s - N : s);
        found = |vec;
    end
endmodule

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: registered fixed/round-robin priority picker with valid/ready output stage
// Optional grant_onehot output when PRIORITY_PICKER_ONEHOT_EN is defined.
module rr_priority_picker
    import rr_priority_picker_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = DEF_IDX_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               mode,
    input  logic [NUM_REQ-1:0] req,
    input  logic               grant_ready,
    output logic               pending,
    output logic               grant_valid,
    output logic [IDX_W-1:0]   grant_idx
`ifdef PRIORITY_PICKER_ONEHOT_EN
    ,
    output logic [NUM_REQ-1:0] grant_onehot
`endif
);
    logic [NUM_REQ-1:0] cand;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   fx_idx;
    logic [IDX_W-1:0]   rr_idx;
    logic [IDX_W-1:0]   pick;
    logic               fx_found;
    logic               rr_found;
    logic               accept;
    logic               load;

    // Excluding the held entry keeps a still-asserted requester from being re-granted back-to-back
    assign cand    = req & ~(grant_valid ? (NUM_REQ'(1) << grant_idx) : '0);
    assign pending = (|req) & enable;
    assign accept  = grant_valid & grant_ready;
    assign pick    = (mode == PICK_RR) ? rr_idx : fx_idx;
    assign load    = enable & (!grant_valid | grant_ready) & ((mode == PICK_RR) ? rr_found : fx_found);

    rr_find_first #(.N(NUM_REQ), .W(IDX_W)) u_fixed (
        .vec(cand), .ptr('0), .idx(fx_idx), .found(fx_found)
    );
    rr_find_first #(.N(NUM_REQ), .W(IDX_W)) u_rr (
        .vec(cand), .ptr(ptr), .idx(rr_idx), .found(rr_found)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_valid <= 1'b0;
            grant_idx   <= '0;
            ptr         <= '0;
        end else begin
            if (load) begin
                grant_valid <= 1'b1;
                grant_idx   <= pick;
            end else if (accept) begin
                grant_valid <= 1'b0;
            end
            if (accept) ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

`ifdef PRIORITY_PICKER_ONEHOT_EN
    always_ff @(posedge clk) begin
        if (rst) grant_onehot <= '0;
        else if (load) grant_onehot <= NUM_REQ'(1) << pick;
        else if (accept) grant_onehot <= '0;
    end
`endif
endmodule
